// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared types, default widths and decode tables for the
//               multi-cycle instruction controller.
//               - state_t     : controller FSM states
//               - alu_decode  : {op,inst,immin} -> ALU operation select
//               - ext_decode  : {op,inst}       -> immediate extender select
//               - is_store / is_load / is_writes : instruction classifiers
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    localparam int OP_W_DEF        = 2;
    localparam int INST_W_DEF      = 2;
    localparam int ALU_W_DEF       = 3;
    localparam int EXT_W_DEF       = 2;
    localparam int MEM_TIMEOUT_DEF = 15;

    localparam int KEY_W     = OP_W_DEF + INST_W_DEF + 1;
    localparam int EXT_KEY_W = OP_W_DEF + INST_W_DEF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    // ALU select table. op=11 is the register/immediate ALU class, op=10 the
    // memory class (address add for plain load/store), op=01 the compare
    // class. Codes not listed select operation 0.
    function automatic logic [ALU_W_DEF-1:0] alu_decode(input logic [KEY_W-1:0] key);
        logic [ALU_W_DEF-1:0] res;
        case (key)
            5'b11000, 5'b11001: res = 3'd1;
            5'b11010, 5'b11011: res = 3'd2;
            5'b11100, 5'b11101: res = 3'd3;
            5'b11110, 5'b11111: res = 3'd4;
            5'b10000, 5'b10010: res = 3'd1;
            5'b10001, 5'b10011: res = 3'd5;
            5'b10100, 5'b10101: res = 3'd6;
            5'b01000, 5'b01010: res = 3'd2;
            5'b01001:           res = 3'd7;
            default:            res = 3'd0;
        endcase
        return res;
    endfunction

    // Extender select table; unlisted codes select 0.
    function automatic logic [EXT_W_DEF-1:0] ext_decode(input logic [EXT_KEY_W-1:0] key);
        logic [EXT_W_DEF-1:0] res;
        case (key)
            4'b1000, 4'b1001: res = 2'd1;
            4'b1010:          res = 2'd2;
            4'b1100:          res = 2'd2;
            4'b1110:          res = 2'd3;
            4'b0100, 4'b0101: res = 2'd3;
            default:          res = 2'd0;
        endcase
        return res;
    endfunction

    function automatic logic is_store(input logic [1:0] op, input logic [1:0] inst,
                                      input logic immin);
        return (op == 2'b10) && (inst == 2'b00) && !immin;
    endfunction

    function automatic logic is_load(input logic [1:0] op, input logic [1:0] inst,
                                     input logic immin);
        return (op == 2'b10) && (inst == 2'b01) && !immin;
    endfunction

    function automatic logic is_writes(input logic [1:0] op, input logic [1:0] inst,
                                       input logic immin);
        return (op == 2'b11) ||
               ((op == 2'b10) && (inst != 2'b11) && !is_store(op, inst, immin));
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_if
// Description : Instruction handshake, flush and memory/control bus of the
//               multi-cycle controller.
//               master : instruction source / memory side (drives
//                        instr_valid, op, inst, immin, flush, mem_ack)
//               slave  : the controller (drives instr_ready, strobes,
//                        alu_ins, ext_sel, busy, timeout_err)
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if #(
    parameter int OP_W   = 2,
    parameter int INST_W = 2,
    parameter int ALU_W  = 3,
    parameter int EXT_W  = 2
);
    logic              instr_valid;
    logic              instr_ready;
    logic [OP_W-1:0]   op;
    logic [INST_W-1:0] inst;
    logic              immin;
    logic              flush;
    logic              mem_ack;
    logic              mem_req;
    logic              wmem;
    logic              rmem;
    logic              wreg;
    logic              immout;
    logic [ALU_W-1:0]  alu_ins;
    logic [EXT_W-1:0]  ext_sel;
    logic              busy;
    logic              timeout_err;

    modport master (
        output instr_valid, op, inst, immin, flush, mem_ack,
        input  instr_ready, mem_req, wmem, rmem, wreg, immout,
               alu_ins, ext_sel, busy, timeout_err
    );

    modport slave (
        input  instr_valid, op, inst, immin, flush, mem_ack,
        output instr_ready, mem_req, wmem, rmem, wreg, immout,
               alu_ins, ext_sel, busy, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode
// Description : Combinational instruction classifier / control decoder.
//               i_op, i_inst, i_immin : raw instruction fields
//               o_store, o_load, o_writes : instruction class flags
//               o_alu : ALU operation select, o_ext : extender select
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W   = OP_W_DEF,
    parameter int INST_W = INST_W_DEF,
    parameter int ALU_W  = ALU_W_DEF,
    parameter int EXT_W  = EXT_W_DEF
) (
    input  logic [OP_W-1:0]   i_op,
    input  logic [INST_W-1:0] i_inst,
    input  logic              i_immin,
    output logic              o_store,
    output logic              o_load,
    output logic              o_writes,
    output logic [ALU_W-1:0]  o_alu,
    output logic [EXT_W-1:0]  o_ext
);

    // The tables are defined on the default 2-bit fields.
    logic [1:0] w_op2;
    logic [1:0] w_inst2;

    assign w_op2   = 2'(i_op);
    assign w_inst2 = 2'(i_inst);

    assign o_store  = is_store(w_op2, w_inst2, i_immin);
    assign o_load   = is_load(w_op2, w_inst2, i_immin);
    assign o_writes = is_writes(w_op2, w_inst2, i_immin);
    assign o_alu    = ALU_W'(alu_decode({w_op2, w_inst2, i_immin}));
    assign o_ext    = EXT_W'(ext_decode({w_op2, w_inst2}));

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Registered multi-cycle instruction controller. Accepts one
//               {op, inst, immin} per transaction and walks it through
//               DECODE -> EXEC -> (MEM) -> (WB), driving one stage's
//               enables at a time.
//               clk, rst : clock, synchronous active-high reset
//               bus      : multicycle_ctrl_if.slave (handshake, flush,
//                          memory ack/request, control strobes, status)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OP_W        = OP_W_DEF,
    parameter int INST_W      = INST_W_DEF,
    parameter int ALU_W       = ALU_W_DEF,
    parameter int EXT_W       = EXT_W_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.slave   bus
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t            r_state;
    state_t            w_next;

    logic [OP_W-1:0]   r_op;
    logic [INST_W-1:0] r_inst;
    logic              r_imm;
    logic              r_store;
    logic              r_load;
    logic              r_writes;
    logic [ALU_W-1:0]  r_alu;
    logic [EXT_W-1:0]  r_ext;
    logic [CNT_W-1:0]  r_wait;
    logic              r_to_err;

    logic              w_store;
    logic              w_load;
    logic              w_writes;
    logic [ALU_W-1:0]  w_alu;
    logic [EXT_W-1:0]  w_ext;
    logic              w_accept;
    logic              w_to_hit;
    logic              w_timeout;

    logic              w_ready;
    logic              w_busy;
    logic              w_mem_req;
    logic              w_wmem;
    logic              w_rmem;
    logic              w_wreg;
    logic [ALU_W-1:0]  w_alu_out;
    logic [EXT_W-1:0]  w_ext_out;

    // Decoding runs on the latched fields during DECODE and is captured at
    // the end of that cycle, so every control output comes from a register.
    ctrl_decode #(
        .OP_W   (OP_W),
        .INST_W (INST_W),
        .ALU_W  (ALU_W),
        .EXT_W  (EXT_W)
    ) u_decode (
        .i_op     (r_op),
        .i_inst   (r_inst),
        .i_immin  (r_imm),
        .o_store  (w_store),
        .o_load   (w_load),
        .o_writes (w_writes),
        .o_alu    (w_alu),
        .o_ext    (w_ext)
    );

    // A flush in IDLE refuses the instruction even though instr_ready is up.
    assign w_accept = (r_state == IDLE) && bus.instr_valid && !bus.flush;

    // The counter holds the number of completed ack-less MEM cycles, so the
    // limit is hit on the MEM_TIMEOUT-th waiting cycle.
    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout_on
            assign w_to_hit = (r_wait == CNT_W'(MEM_TIMEOUT - 1));
        end else begin : g_timeout_off
            assign w_to_hit = 1'b0;
        end
    endgenerate

    // An ack in the same cycle wins over the timeout; a flush wins over both.
    assign w_timeout = (r_state == MEM) && !bus.mem_ack && !bus.flush && w_to_hit;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        if (bus.flush) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:   w_next = w_accept ? DECODE : IDLE;
                DECODE: w_next = EXEC;
                EXEC: begin
                    if (r_store || r_load) begin
                        w_next = MEM;
                    end else if (r_writes) begin
                        w_next = WB;
                    end else begin
                        w_next = IDLE;
                    end
                end
                MEM: begin
                    if (bus.mem_ack) begin
                        w_next = r_load ? WB : IDLE;
                    end else if (w_timeout) begin
                        w_next = IDLE;
                    end
                end
                WB:      w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_ready   = 1'b0;
        w_busy    = 1'b1;
        w_mem_req = 1'b0;
        w_wmem    = 1'b0;
        w_rmem    = 1'b0;
        w_wreg    = 1'b0;
        w_alu_out = '0;
        w_ext_out = '0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                w_busy  = 1'b0;
            end
            DECODE: begin
            end
            EXEC: begin
                w_alu_out = r_alu;
                w_ext_out = r_ext;
            end
            MEM: begin
                w_mem_req = 1'b1;
                w_wmem    = r_store;
                w_rmem    = r_load;
                w_alu_out = r_alu;
                w_ext_out = r_ext;
            end
            WB: begin
                w_wreg    = 1'b1;
                w_alu_out = r_alu;
                w_ext_out = r_ext;
            end
            default: begin
                w_ready = 1'b1;
                w_busy  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------ instruction latches
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_inst   <= '0;
            r_imm    <= 1'b0;
            r_store  <= 1'b0;
            r_load   <= 1'b0;
            r_writes <= 1'b0;
            r_alu    <= '0;
            r_ext    <= '0;
        end else begin
            if (w_accept) begin
                r_op   <= bus.op;
                r_inst <= bus.inst;
                r_imm  <= bus.immin;
            end
            if (r_state == DECODE) begin
                r_store  <= w_store;
                r_load   <= w_load;
                r_writes <= w_writes;
                r_alu    <= w_alu;
                r_ext    <= w_ext;
            end
        end
    end

    // ------------------------------------------------ memory wait counter
    always_ff @(posedge clk) begin
        if (rst || (r_state != MEM)) begin
            r_wait <= '0;
        end else if (!bus.mem_ack) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_err <= 1'b0;
        end else begin
            r_to_err <= w_timeout;
        end
    end

    assign bus.instr_ready = w_ready;
    assign bus.busy        = w_busy;
    assign bus.mem_req     = w_mem_req;
    assign bus.wmem        = w_wmem;
    assign bus.rmem        = w_rmem;
    assign bus.wreg        = w_wreg;
    assign bus.immout      = r_imm;
    assign bus.alu_ins     = w_alu_out;
    assign bus.ext_sel     = w_ext_out;
    assign bus.timeout_err = r_to_err;

endmodule
`default_nettype wire
